// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared types and helpers for the buffered UART transmitter.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

   // Parity selection; any other value is treated as no parity.
   typedef enum logic [1:0] {
      PAR_NONE = 2'd0,
      PAR_ODD  = 2'd1,
      PAR_EVEN = 2'd2
   } parity_e;

   // Transmitter frame states.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_e;

   // Clock cycles occupied by one complete frame on the serial line.
   function automatic int frame_cycles(input int cpb, input int dbits,
                                       input int pmode, input int sbits);
      int par;
      par = (pmode == int'(PAR_ODD) || pmode == int'(PAR_EVEN)) ? 1 : 0;
      return cpb * (1 + dbits + par + sbits);
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_fifo
// Purpose  : Synchronous FIFO with combinational head read and occupancy count.
// Revision : 1.0 - initial release
// ============================================================================
module uart_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   import uart_pkg::*;

   localparam int                 c_ADDR_W = $clog2(DEPTH);
   localparam logic [c_ADDR_W:0]  c_FULL   = (c_ADDR_W + 1)'(DEPTH);

   logic [WIDTH-1:0]    r_mem [DEPTH];
   logic [c_ADDR_W-1:0] r_wr_ptr;
   logic [c_ADDR_W-1:0] r_rd_ptr;
   logic [c_ADDR_W:0]   r_count;
   logic                w_do_push;
   logic                w_do_pop;

   // A push into a full FIFO is dropped even when a pop frees a slot this cycle.
   assign w_do_push = push && !full;
   assign w_do_pop  = pop && !empty;

   assign full     = (r_count == c_FULL);
   assign empty    = (r_count == '0);
   assign count    = r_count;
   assign pop_data = r_mem[r_rd_ptr];

   // Storage array; contents need no reset because count gates every read.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= push_data;
      end
   end

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_do_push && !w_do_pop) begin
            r_count <= r_count + 1'b1;
         end else if (!w_do_push && w_do_pop) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_tx_buffered.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_buffered
// Purpose  : UART transmitter fed by a small FIFO; configurable data width,
//            parity, stop bits and bit period. Frames go out back to back.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_buffered #(
   parameter int CLOCKS_PER_BIT = 3,
   parameter int DATA_BITS      = 8,
   parameter int PARITY_MODE    = 0,
   parameter int STOP_BITS      = 1,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [DATA_BITS-1:0]          in_data,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic                          ser_tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
   import uart_pkg::*;

   localparam int   c_TIMER_W = $clog2(CLOCKS_PER_BIT);
   localparam int   c_BIT_W   = $clog2(DATA_BITS);
   localparam logic [c_TIMER_W-1:0] c_TIMER_MAX = c_TIMER_W'(CLOCKS_PER_BIT - 1);
   localparam logic [c_BIT_W-1:0]   c_BIT_MAX   = c_BIT_W'(DATA_BITS - 1);
   localparam logic                 c_STOP_MAX  = 1'(STOP_BITS - 1);
   // Mode 3 (unused encoding) falls through to "no parity".
   localparam logic c_PAR_EN  = (PARITY_MODE == int'(PAR_ODD)) ||
                                (PARITY_MODE == int'(PAR_EVEN));
   localparam logic c_PAR_ODD = (PARITY_MODE == int'(PAR_ODD));

   tx_state_e              r_state,  w_state_nx;
   logic [c_TIMER_W-1:0]   r_timer,  w_timer_nx;
   logic [c_BIT_W-1:0]     r_bit_idx, w_bit_nx;
   logic                   r_stop_idx, w_stop_nx;
   logic [DATA_BITS-1:0]   r_shift,  w_shift_nx;
   logic                   r_parity, w_parity_nx;
   logic                   r_ser_tx, w_ser_nx;

   logic                   w_tick;
   logic                   w_load;
   logic                   w_push;
   logic                   w_fifo_full;
   logic                   w_fifo_empty;
   logic [DATA_BITS-1:0]   w_pop_data;

   assign w_push   = in_valid && in_ready;
   assign in_ready = !w_fifo_full;
   assign ser_tx   = r_ser_tx;
   assign busy     = (r_state != IDLE);
   assign w_tick   = (r_timer == c_TIMER_MAX);

   uart_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (w_push),
      .push_data (in_data),
      .pop       (w_load),
      .pop_data  (w_pop_data),
      .full      (w_fifo_full),
      .empty     (w_fifo_empty),
      .count     (fifo_count)
   );

   // Frame state register; the serial line is registered so it never glitches.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_timer    <= '0;
         r_bit_idx  <= '0;
         r_stop_idx <= 1'b0;
         r_shift    <= '0;
         r_parity   <= 1'b0;
         r_ser_tx   <= 1'b1;
      end else begin
         r_state    <= w_state_nx;
         r_timer    <= w_timer_nx;
         r_bit_idx  <= w_bit_nx;
         r_stop_idx <= w_stop_nx;
         r_shift    <= w_shift_nx;
         r_parity   <= w_parity_nx;
         r_ser_tx   <= w_ser_nx;
      end
   end

   // Next-state logic; ser_tx is computed for the bit that starts on the next edge.
   always_comb begin
      w_state_nx  = r_state;
      w_timer_nx  = w_tick ? '0 : r_timer + 1'b1;
      w_bit_nx    = r_bit_idx;
      w_stop_nx   = r_stop_idx;
      w_shift_nx  = r_shift;
      w_parity_nx = r_parity;
      w_ser_nx    = r_ser_tx;
      w_load      = 1'b0;

      unique case (r_state)
         IDLE: begin
            w_timer_nx = '0;
            w_ser_nx   = 1'b1;
            w_load     = !w_fifo_empty;
         end
         START: begin
            if (w_tick) begin
               w_state_nx = DATA;
               w_bit_nx   = '0;
               w_ser_nx   = r_shift[0];
            end
         end
         DATA: begin
            if (w_tick) begin
               if (r_bit_idx == c_BIT_MAX) begin
                  if (c_PAR_EN) begin
                     w_state_nx = PARITY;
                     w_ser_nx   = r_parity;
                  end else begin
                     w_state_nx = STOP;
                     w_stop_nx  = 1'b0;
                     w_ser_nx   = 1'b1;
                  end
               end else begin
                  w_bit_nx   = r_bit_idx + 1'b1;
                  w_shift_nx = r_shift >> 1;
                  w_ser_nx   = r_shift[1];
               end
            end
         end
         PARITY: begin
            if (w_tick) begin
               w_state_nx = STOP;
               w_stop_nx  = 1'b0;
               w_ser_nx   = 1'b1;
            end
         end
         STOP: begin
            if (w_tick) begin
               if (r_stop_idx == c_STOP_MAX) begin
                  // Chain straight into the next frame when one is waiting.
                  if (!w_fifo_empty) begin
                     w_load = 1'b1;
                  end else begin
                     w_state_nx = IDLE;
                     w_ser_nx   = 1'b1;
                  end
               end else begin
                  w_stop_nx = r_stop_idx + 1'b1;
               end
            end
         end
         default: begin
            w_state_nx = IDLE;
            w_ser_nx   = 1'b1;
         end
      endcase

      // Loading a word also launches its start bit on the same edge.
      if (w_load) begin
         w_state_nx  = START;
         w_timer_nx  = '0;
         w_shift_nx  = w_pop_data;
         w_parity_nx = c_PAR_ODD ? ~^w_pop_data : ^w_pop_data;
         w_ser_nx    = 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_buffered.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_buffered
// Purpose  : Self-checking bench; four transmitter variants share one stimulus
//            stream and are compared against a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_buffered;

   localparam int CPB = 3;
   localparam int NI  = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_valid;
   logic [7:0]      in_data;
   logic [3:0]      ser;
   logic [3:0]      busy;
   logic [3:0]      rdy;
   logic [3:0][2:0] cnt;

   int n_checks;
   int n_fail;

   // Reference model: per instance, queued words and cycles left in the frame.
   int          m_left [NI];
   int          m_n    [NI];
   logic [7:0]  m_buf  [NI][4];
   logic [7:0]  m_cur  [NI];

   // Serial decoder on instance 0 (8N1).
   bit          d_active;
   int          d_t;
   logic [7:0]  d_word;
   logic [7:0]  dec_q [$];

   typedef struct {
      logic [7:0] data;
      int         len0;
      int         len1;
      int         len2;
      int         len3;
      logic       par_odd;
      logic       par_even;
      int         tail3;
   } vec_t;

   vec_t  vecs [6];
   int    t_c [NI];
   logic  t_par [NI];
   int    t_tail;
   int    exp_len [NI];
   string hello;
   int    k;
   int    quiet_bad;
   logic  acc;

   always #5 clk = ~clk;

   uart_tx_buffered #(.CLOCKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0),
                      .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .in_data(in_data[7:0]), .in_valid(in_valid),
      .in_ready(rdy[0]), .ser_tx(ser[0]), .busy(busy[0]), .fifo_count(cnt[0]));

   uart_tx_buffered #(.CLOCKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1),
                      .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_data(in_data[7:0]), .in_valid(in_valid),
      .in_ready(rdy[1]), .ser_tx(ser[1]), .busy(busy[1]), .fifo_count(cnt[1]));

   uart_tx_buffered #(.CLOCKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2),
                      .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .in_data(in_data[7:0]), .in_valid(in_valid),
      .in_ready(rdy[2]), .ser_tx(ser[2]), .busy(busy[2]), .fifo_count(cnt[2]));

   uart_tx_buffered #(.CLOCKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(0),
                      .STOP_BITS(2), .FIFO_DEPTH(4)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .in_data(in_data[6:0]), .in_valid(in_valid),
      .in_ready(rdy[3]), .ser_tx(ser[3]), .busy(busy[3]), .fifo_count(cnt[3]));

   function automatic int db_of(input int i);
      return (i == 3) ? 7 : 8;
   endfunction

   function automatic int pm_of(input int i);
      return (i == 1) ? 1 : ((i == 2) ? 2 : 0);
   endfunction

   function automatic int sb_of(input int i);
      return (i == 3) ? 2 : 1;
   endfunction

   function automatic int flen(input int i);
      return CPB * (1 + db_of(i) + ((pm_of(i) != 0) ? 1 : 0) + sb_of(i));
   endfunction

   // Bit number idx of the frame carrying word w: start, LSB-first data, parity, stops.
   function automatic logic frame_bit(input int i, input logic [7:0] w, input int idx);
      int db;
      int ones;
      db   = db_of(i);
      ones = $countones(w & 8'((1 << db) - 1));
      if (idx == 0) return 1'b0;
      if (idx <= db) return w[idx-1];
      if (pm_of(i) != 0 && idx == db + 1) return (pm_of(i) == 2) ? ones[0] : ~ones[0];
      return 1'b1;
   endfunction

   task automatic chk(input string name, input int inst,
                      input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s inst=%0d got=%0h exp=%0h t=%0t", name, inst, got, exp, $time);
      end
   endtask

   // Advance the model across one clock edge using the inputs applied to it.
   task automatic model_update();
      for (int i = 0; i < NI; i++) begin
         logic do_pop;
         logic do_push;
         if (!rst_n) begin
            m_left[i] = 0;
            m_n[i]    = 0;
         end else begin
            do_pop  = (m_left[i] <= 1) && (m_n[i] > 0);
            do_push = in_valid && (m_n[i] < 4);
            if (m_left[i] > 0) m_left[i]--;
            if (do_pop) begin
               m_cur[i] = m_buf[i][0];
               for (int j = 0; j < 3; j++) m_buf[i][j] = m_buf[i][j+1];
               m_n[i]--;
               m_left[i] = flen(i);
            end
            if (do_push) begin
               m_buf[i][m_n[i]] = in_data;
               m_n[i]++;
            end
         end
      end
   endtask

   task automatic check_all();
      logic exp_ser;
      for (int i = 0; i < NI; i++) begin
         exp_ser = (m_left[i] > 0) ? frame_bit(i, m_cur[i], (flen(i) - m_left[i]) / CPB) : 1'b1;
         chk("ser_tx", i, ser[i], exp_ser);
         chk("busy", i, busy[i], m_left[i] > 0);
         chk("fifo_count", i, cnt[i], m_n[i]);
         chk("in_ready", i, rdy[i], m_n[i] < 4);
      end
   endtask

   task automatic decode();
      if (!rst_n) begin
         d_active = 1'b0;
      end else if (!d_active) begin
         if (ser[0] == 1'b0) begin
            d_active = 1'b1;
            d_t      = 0;
            d_word   = '0;
         end
      end else begin
         d_t++;
         if (d_t >= 4 && d_t <= 25 && (d_t % CPB) == 1) d_word[(d_t - 4) / CPB] = ser[0];
         if (d_t == 28) begin
            dec_q.push_back(d_word);
            d_active = 1'b0;
         end
      end
   endtask

   // One clock: sample #1 after the edge, update model, compare, decode.
   task automatic step();
      @(posedge clk);
      #1;
      model_update();
      check_all();
      decode();
   endtask

   task automatic wait_idle();
      bit done;
      done = 1'b0;
      for (int n = 0; n < 600 && !done; n++) begin
         step();
         done = 1'b1;
         for (int i = 0; i < NI; i++) if (busy[i] || cnt[i] != 3'd0) done = 1'b0;
      end
      chk("idle_timeout", 0, done, 1);
   endtask

   task automatic push_one(input logic [7:0] w);
      in_valid = 1'b1;
      in_data  = w;
      step();
      in_valid = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      d_active = 1'b0;
      d_t      = 0;
      d_word   = '0;
      for (int i = 0; i < NI; i++) begin
         m_left[i] = 0;
         m_n[i]    = 0;
         m_cur[i]  = '0;
      end
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;

      // Reset state
      repeat (3) step();
      for (int i = 0; i < NI; i++) begin
         chk("reset_ser", i, ser[i], 1);
         chk("reset_busy", i, busy[i], 0);
         chk("reset_count", i, cnt[i], 0);
         chk("reset_ready", i, rdy[i], 1);
      end
      rst_n = 1'b1;
      step();

      // Directed single-word frames: lengths, parity bits, stop-bit tail
      vecs[0] = '{8'h55, 30, 33, 33, 30, 1'b1, 1'b0, 6};
      vecs[1] = '{8'h07, 30, 33, 33, 30, 1'b0, 1'b1, 6};
      vecs[2] = '{8'h7F, 30, 33, 33, 30, 1'b0, 1'b1, 6};
      vecs[3] = '{8'h00, 30, 33, 33, 30, 1'b1, 1'b0, 6};
      vecs[4] = '{8'hFF, 30, 33, 33, 30, 1'b1, 1'b0, 6};
      vecs[5] = '{8'h80, 30, 33, 33, 30, 1'b0, 1'b1, 6};
      for (int v = 0; v < 6; v++) begin
         wait_idle();
         push_one(vecs[v].data);
         chk("latency_idle_ser", 0, ser[0], 1);
         chk("latency_count", 0, cnt[0], 1);
         exp_len[0] = vecs[v].len0;
         exp_len[1] = vecs[v].len1;
         exp_len[2] = vecs[v].len2;
         exp_len[3] = vecs[v].len3;
         for (int i = 0; i < NI; i++) begin
            t_c[i]   = 0;
            t_par[i] = 1'bx;
         end
         t_tail = 0;
         repeat (60) begin
            step();
            for (int i = 0; i < NI; i++) begin
               if (busy[i]) begin
                  if (t_c[i] == 28) t_par[i] = ser[i];
                  if (i == 3 && t_c[i] >= 24) t_tail += int'(ser[i]);
                  t_c[i]++;
               end
            end
         end
         for (int i = 0; i < NI; i++) chk("frame_len", i, t_c[i], exp_len[i]);
         chk("parity_odd", 1, t_par[1], vecs[v].par_odd);
         chk("parity_even", 2, t_par[2], vecs[v].par_even);
         chk("stop_tail_high", 3, t_tail, vecs[v].tail3);
      end

      // "Hello" pushed back to back
      wait_idle();
      dec_q.delete();
      hello    = "Hello";
      k        = 0;
      in_valid = 1'b1;
      in_data  = hello[0];
      for (int s = 0; s < 40 && k < 5; s++) begin
         acc = rdy[0];
         step();
         if (acc) begin
            k++;
            if (k < 5) in_data = hello[k];
         end
      end
      in_valid = 1'b0;
      chk("hello_accepted", 0, k, 5);
      chk("hello_full_count", 0, cnt[0], 4);
      chk("hello_in_ready", 0, rdy[0], 0);
      wait_idle();
      chk("hello_decoded_len", 0, dec_q.size(), 5);
      for (int j = 0; j < 5; j++)
         chk("hello_char", j, (j < dec_q.size()) ? dec_q[j] : 8'h00, hello[j]);

      // Push coinciding with the chained pop while two words are queued
      dec_q.delete();
      push_one(8'h11);
      push_one(8'h22);
      push_one(8'h33);
      chk("pp_count_before", 0, cnt[0], 2);
      for (int s = 0; s < 100 && m_left[0] != 1; s++) step();
      chk("pp_wait", 0, m_left[0], 1);
      push_one(8'h44);
      chk("pp_count_same", 0, cnt[0], 2);
      chk("pp_next_start", 0, ser[0], 0);
      wait_idle();
      chk("pp_decoded_len", 0, dec_q.size(), 4);
      for (int j = 0; j < 4; j++)
         chk("pp_order", j, (j < dec_q.size()) ? dec_q[j] : 8'h00, 8'h11 * (j + 1));

      // Reset in the middle of a data phase with two words queued
      push_one(8'hA5);
      push_one(8'h3C);
      push_one(8'hC3);
      repeat (12) step();
      chk("midrst_queued", 0, cnt[0], 2);
      rst_n = 1'b0;
      step();
      for (int i = 0; i < NI; i++) begin
         chk("midrst_ser", i, ser[i], 1);
         chk("midrst_busy", i, busy[i], 0);
         chk("midrst_count", i, cnt[i], 0);
      end
      rst_n     = 1'b1;
      quiet_bad = 0;
      repeat (100) begin
         step();
         for (int i = 0; i < NI; i++) if (ser[i] !== 1'b1 || busy[i] !== 1'b0) quiet_bad++;
      end
      chk("post_reset_quiet", 0, quiet_bad, 0);

      // Randomized traffic with occasional resets
      for (int s = 0; s < 4000; s++) begin
         int thr;
         case (s / 1000)
            0:       thr = 4;
            1:       thr = 16;
            2:       thr = 1;
            default: thr = 8;
         endcase
         in_valid = ($urandom_range(0, 15) < thr);
         in_data  = 8'($urandom_range(0, 255));
         rst_n    = ($urandom_range(0, 799) != 0);
         step();
      end
      rst_n    = 1'b1;
      in_valid = 1'b0;
      wait_idle();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
